// File: rtl/madd_msub_pkg.sv
// Shared definitions for the modular add/subtract sequencer: FSM states,
// default operand length and the datapath select encodings.
package madd_msub_pkg;

  localparam int unsigned MM_WORDS = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_P,
    PASS1,
    PASS2,
    OUT,
    FIN
  } state_t;

  typedef enum logic {MUX0_REGA  = 1'b0, MUX0_REGS0 = 1'b1} mux0_sel_t;
  typedef enum logic {MUX1_REGB  = 1'b0, MUX1_REGP  = 1'b1} mux1_sel_t;
  typedef enum logic {CARRY_REG  = 1'b0, CARRY_ADDSUB = 1'b1} carry_sel_t;

endpackage

// File: rtl/word_cnt.sv
// Word position counter for the serial datapath: counts enabled cycles,
// wraps to zero after WORDS-1 and flags the last word.
module word_cnt #(
  parameter int unsigned WORDS = 16,
  parameter int unsigned CW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(WORDS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (en)
      cnt <= last ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/madd_msub_ctrl.sv
// Sequencer for a word-serial (a+b) mod p / (a-b) mod p datapath: loads three
// operands, runs a raw pass and a correction pass, then streams the result.
module madd_msub_ctrl
  import madd_msub_pkg::*;
#(
  parameter int unsigned WORDS = MM_WORDS
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic res_sel,
  output logic busy,
  output logic done,
  input  logic sign_a_b,
  input  logic sign_a_b_p,
  output logic rega_we,
  output logic regb_we,
  output logic regp_we,
  output logic regs0_we,
  output logic regs1_we,
  output logic dff1_we,
  output logic rega_cyc,
  output logic regb_cyc,
  output logic regp_cyc,
  output logic regs0_cyc,
  output logic regs1_cyc,
  output logic mux0_sel,
  output logic mux1_sel,
  output logic carry_sel,
  output logic add_sub
);

  localparam int unsigned CW = $clog2(WORDS);

  state_t          state_q, state_d;
  logic            op_q;
  logic            cnt_en;
  logic [CW-1:0]   cnt;
  logic            cnt_last;

  word_cnt #(.WORDS(WORDS), .CW(CW)) u_word_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .cnt  (cnt),
    .last (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      res_sel <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start)
        op_q <= op;
      // Subtract decides on the sign of a-b; add decides on the sign of a+b-p.
      if (state_q == PASS1 && cnt_last && op_q)
        res_sel <= sign_a_b;
      if (state_q == PASS2 && cnt_last && !op_q)
        res_sel <= ~sign_a_b_p;
    end
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    // the block leaves a variable unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_en    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    rega_we   = 1'b0;
    regb_we   = 1'b0;
    regp_we   = 1'b0;
    regs0_we  = 1'b0;
    regs1_we  = 1'b0;
    dff1_we   = 1'b0;
    rega_cyc  = 1'b0;
    regb_cyc  = 1'b0;
    regp_cyc  = 1'b0;
    regs0_cyc = 1'b0;
    regs1_cyc = 1'b0;
    mux0_sel  = MUX0_REGA;
    mux1_sel  = MUX1_REGB;
    carry_sel = CARRY_REG;
    add_sub   = 1'b0;

    case (state_q)
      IDLE: if (start) state_d = LOAD_A;

      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          rega_we = 1'b1;
          cnt_en  = 1'b1;
          if (cnt_last) state_d = LOAD_B;
        end
      end

      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          regb_we = 1'b1;
          cnt_en  = 1'b1;
          if (cnt_last) state_d = LOAD_P;
        end
      end

      LOAD_P: begin
        in_ready = 1'b1;
        if (in_valid) begin
          regp_we = 1'b1;
          cnt_en  = 1'b1;
          if (cnt_last) state_d = PASS1;
        end
      end

      PASS1: begin
        cnt_en    = 1'b1;
        mux0_sel  = MUX0_REGA;
        mux1_sel  = MUX1_REGB;
        add_sub   = op_q;
        rega_cyc  = 1'b1;
        regb_cyc  = 1'b1;
        regs0_we  = 1'b1;
        carry_sel = (cnt == '0) ? CARRY_ADDSUB : CARRY_REG;
        dff1_we   = cnt_last;
        if (cnt_last) state_d = PASS2;
      end

      // Correction pass: add p back after a-b, or try a+b-p after an add.
      PASS2: begin
        cnt_en    = 1'b1;
        mux0_sel  = MUX0_REGS0;
        mux1_sel  = MUX1_REGP;
        add_sub   = ~op_q;
        regs0_cyc = 1'b1;
        regp_cyc  = 1'b1;
        regs1_we  = 1'b1;
        carry_sel = (cnt == '0) ? CARRY_ADDSUB : CARRY_REG;
        if (cnt_last) state_d = OUT;
      end

      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_en    = 1'b1;
          regs0_cyc = ~res_sel;
          regs1_cyc = res_sel;
          if (cnt_last) state_d = FIN;
        end
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_madd_msub_ctrl.sv
// Bench for madd_msub_ctrl: a behavioural word-serial datapath around the
// controller, a vector table and a scoreboard of expected result words.
module tb_madd_msub_ctrl;

  localparam int W      = 16;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst, start, op, in_valid, out_ready, sign_a_b, sign_a_b_p;
  logic in_ready, out_valid, res_sel, busy, done;
  logic rega_we, regb_we, regp_we, regs0_we, regs1_we, dff1_we;
  logic rega_cyc, regb_cyc, regp_cyc, regs0_cyc, regs1_cyc;
  logic mux0_sel, mux1_sel, carry_sel, add_sub;
  logic [15:0] datain;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic         op;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] p;
    logic [255:0] exp_r;
    logic         exp_sel;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  madd_msub_ctrl #(.WORDS(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_sel(res_sel), .busy(busy), .done(done),
    .sign_a_b(sign_a_b), .sign_a_b_p(sign_a_b_p),
    .rega_we(rega_we), .regb_we(regb_we), .regp_we(regp_we),
    .regs0_we(regs0_we), .regs1_we(regs1_we), .dff1_we(dff1_we),
    .rega_cyc(rega_cyc), .regb_cyc(regb_cyc), .regp_cyc(regp_cyc),
    .regs0_cyc(regs0_cyc), .regs1_cyc(regs1_cyc),
    .mux0_sel(mux0_sel), .mux1_sel(mux1_sel),
    .carry_sel(carry_sel), .add_sub(add_sub)
  );

  wire [19:0] all_out = {in_ready, out_valid, res_sel, busy, done,
                         rega_we, regb_we, regp_we, regs0_we, regs1_we, dff1_we,
                         rega_cyc, regb_cyc, regp_cyc, regs0_cyc, regs1_cyc,
                         mux0_sel, mux1_sel, carry_sel, add_sub};

  // Behavioural datapath: word 0 of each register is the one presented.
  logic [W-1:0][15:0] ra, rb, rp, rs0, rs1;
  logic        creg, dff1;
  logic [15:0] x0, x1, y1, sum, dp_out;
  logic        cin, cout;

  always_comb begin
    x0 = mux0_sel ? rs0[0] : ra[0];
    x1 = mux1_sel ? rp[0] : rb[0];
    y1 = add_sub ? ~x1 : x1;
    cin = carry_sel ? add_sub : creg;
    {cout, sum} = {1'b0, x0} + {1'b0, y1} + {16'b0, cin};
    dp_out = res_sel ? rs1[0] : rs0[0];
  end

  assign sign_a_b   = ~cout;
  assign sign_a_b_p = ~cout & ~dff1;

  always @(posedge clk) begin
    creg <= cout;
    if (dff1_we) dff1 <= cout;
    if (rega_we) ra <= {datain, ra[W-1:1]};
    else if (rega_cyc) ra <= {ra[0], ra[W-1:1]};
    if (regb_we) rb <= {datain, rb[W-1:1]};
    else if (regb_cyc) rb <= {rb[0], rb[W-1:1]};
    if (regp_we) rp <= {datain, rp[W-1:1]};
    else if (regp_cyc) rp <= {rp[0], rp[W-1:1]};
    if (regs0_we) rs0 <= {sum, rs0[W-1:1]};
    else if (regs0_cyc) rs0 <= {rs0[0], rs0[W-1:1]};
    if (regs1_we) rs1 <= {sum, rs1[W-1:1]};
    else if (regs1_cyc) rs1 <= {rs1[0], rs1[W-1:1]};
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_calc(input logic opx, input logic [255:0] a, input logic [255:0] b,
                                   input logic [255:0] p, output logic [255:0] r, output logic sel);
    logic [256:0] s;
    if (!opx) begin
      s   = {1'b0, a} + {1'b0, b};
      sel = (s >= {1'b0, p});
      r   = sel ? 256'(s - {1'b0, p}) : s[255:0];
    end else begin
      sel = (a < b);
      r   = sel ? a - b + p : a - b;
    end
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] t;
    for (int k = 0; k < 8; k++) t[32*k +: 32] = $urandom;
    return t;
  endfunction

  // rst_cyc > 0 aborts the operation with a reset pulse after that many cycles.
  task automatic run_op(input vec_t v, input bit gaps, input bit stall, input bit hold_start,
                        input bit chk_lat, input int rst_cyc);
    logic [15:0] words[3*W];
    int idx = 0, outn = 0, cyc = 0, stall_left;
    bit seen_done = 1'b0;
    for (int i = 0; i < W; i++) begin
      words[i]       = v.a[16*i +: 16];
      words[W+i]     = v.b[16*i +: 16];
      words[2*W+i]   = v.p[16*i +: 16];
      exp_q.push_back(v.exp_r[16*i +: 16]);
    end
    stall_left = stall ? 5 : 0;

    @(negedge clk);
    op = v.op; start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;

    while (!seen_done && cyc < BUDGET) begin
      @(negedge clk);
      start = hold_start && in_ready;
      if (idx < 3*W) begin
        in_valid = !gaps || ($urandom_range(0, 2) != 0);
        datain   = words[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) idx++;
      out_ready = 1'b1;
      if (out_valid && stall && outn == 3 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end
      #1;
      if (gaps && in_ready && !in_valid)
        check("no_we_in_gap", {rega_we, regb_we, regp_we}, 0);
      if (out_valid && !out_ready)
        check("no_cyc_in_stall", {regs0_cyc, regs1_cyc, out_valid}, 3'b001);
      if (out_valid && out_ready) begin
        if (outn == 0) check("res_sel", res_sel, v.exp_sel);
        check("scoreboard_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check($sformatf("word%0d", outn), dp_out, exp_q.pop_front());
        outn++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (rst_cyc > 0 && cyc == rst_cyc) begin
        check("pass1_active", {regs0_we, rega_cyc, regb_cyc}, 3'b111);
        @(negedge clk);
        rst = 1'b1;
        #1 check("outputs_in_reset", all_out, 0);
        @(posedge clk);
        #1 check("outputs_after_reset_edge", all_out, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      if (done) seen_done = 1'b1;
    end

    check("done_within_budget", seen_done, 1);
    // Counted from the cycle in which start is sampled, inclusive.
    if (chk_lat) check("latency", cyc + 1, 6*W + 1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; in_valid = 1'b0; out_ready = 1'b0; datain = '0;

    vecs[0] = '{op: 1'b0, a: 256'd5,  b: 256'd9, p: 256'd13, exp_r: 256'd1, exp_sel: 1'b1};
    vecs[1] = '{op: 1'b1, a: 256'd5,  b: 256'd9, p: 256'd13, exp_r: 256'd9, exp_sel: 1'b1};
    vecs[2] = '{op: 1'b0, a: 256'd12, b: 256'd1, p: 256'd13, exp_r: 256'd0, exp_sel: 1'b1};
    vecs[3] = '{op: 1'b1, a: 256'd9,  b: 256'd9, p: 256'd13, exp_r: 256'd0, exp_sel: 1'b0};
    for (int i = 4; i < 6; i++) begin
      vecs[i].op = (i == 5);
      vecs[i].p  = rand256() | {1'b1, 255'b0};
      vecs[i].a  = rand256() % vecs[i].p;
      vecs[i].b  = rand256() % vecs[i].p;
      ref_calc(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].exp_r, vecs[i].exp_sel);
    end

    repeat (2) @(posedge clk);
    #1 check("reset_outputs", all_out, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("idle_outputs", all_out, 0);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i], 1'b0, 1'b0, 1'b0, (i == 0), 0);

    run_op(vecs[0], 1'b1, 1'b1, 1'b1, 1'b0, 0);
    run_op(vecs[5], 1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Abort on PASS1 word 7, then a fresh operation must still be correct.
    run_op(vecs[4], 1'b0, 1'b0, 1'b0, 1'b0, 3*W + 7);
    run_op(vecs[1], 1'b0, 1'b0, 1'b0, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
